divisor_peso: RTL and testbench
===============================

DIVISOR_PESO -- requirements
Module: divisor_peso

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 preco  input  10  target price, whole euros, 0..1023.
REQ-007 precofr  input  10  target price, cents part; legal range 0..99.
REQ-008 centimos  input  10  unit price in cents per kg, 0..1023.
REQ-009 weightInGrams  output  12  computed weight in grams, registered.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse when results are updated.
REQ-012 err  output  1  input error flag for the last result.
REQ-013 ovf  output  1  saturation flag for the last result.

Function
REQ-014 The block SHALL compute weightInGrams = floor((preco*100 + precofr)*1000 / centimos), the inverse of the price multiplier.
REQ-015 Total cents SHALL be 17 bits; the numerator SHALL be 27 bits (max 102399000) with no truncation.
REQ-016 Division SHALL be restoring, one quotient bit per clock, 27 iterations, MSB first.
REQ-017 The FSM SHALL have four states: IDLE, LOAD, DIV, FIN.
REQ-018 IDLE with start=1 at edge k SHALL latch preco, precofr and centimos and go to LOAD.
REQ-019 LOAD at edge k+1 SHALL form the numerator, clear the remainder, set the iteration count to 26 and go to DIV.
REQ-020 DIV SHALL perform one iteration per edge (k+2..k+28) and go to FIN after the iteration with count 0.
REQ-021 FIN at edge k+29 SHALL update weightInGrams, err and ovf, pulse done for exactly one cycle, and return to IDLE.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 Latency SHALL be 29 clocks from the start-sampling edge to done high.
REQ-024 The next start SHALL be accepted no earlier than the edge at which done is high.
REQ-025 start while busy SHALL be ignored, with no effect on the running operation or the latched operands.
REQ-026 Inputs SHALL be sampled only at edge k; later input changes SHALL NOT affect the result.
REQ-027 If centimos==0 or precofr>99, LOAD SHALL go directly to FIN, and FIN SHALL write weightInGrams=0, err=1, ovf=0 (latency 2 clocks).
REQ-028 A quotient >4095 SHALL give weightInGrams=4095, ovf=1, err=0.
REQ-029 Otherwise FIN SHALL write the 12-bit quotient with err=0 and ovf=0.
REQ-030 weightInGrams, err and ovf SHALL hold their values between done pulses.
REQ-031 Numerator 0 with a nonzero divisor SHALL give weightInGrams=0 with no flags.

Reset
REQ-032 When rst=1, the block SHALL asynchronously force state=IDLE, weightInGrams=0, busy=0, done=0, err=0 and ovf=0, and clear internal registers.
REQ-033 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-034 After rst falls, the first start SHALL be accepted on the next rising edge.

Verification
REQ-035 preco=7, precofr=5, centimos=470, start pulse -> done 29 clocks later; weightInGrams=1500, err=0, ovf=0.
REQ-036 preco=1, precofr=0, centimos=300 -> weightInGrams=333 (floor); preco=0, precofr=0, centimos=5 -> weightInGrams=0, no flags.
REQ-037 preco=10, precofr=0, centimos=100 (quotient 10000) -> weightInGrams=4095, ovf=1; then centimos=0 -> weightInGrams=0, err=1, done 2 clocks after start; then precofr=150 -> err=1.
REQ-038 start re-pulsed and inputs changed at cycles 5 and 20 of a 7.05/470 run -> single done, weightInGrams=1500, busy continuously high.
REQ-039 rst asserted at cycle 15 of a run -> all outputs 0 immediately, no done; a new start after release completes normally.

Source files
------------

// File: rtl/divisor_peso.sv
// divisor_peso: weight-from-price calculator.
// weightInGrams = floor((preco*100 + precofr) * 1000 / centimos), computed by a
// restoring divider that retires one quotient bit per clock, MSB first.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// LOAD  | build numerator, clear remainder, arm iteration counter
// DIV   | one restoring-division iteration per clock (27 total)
// FIN   | publish result/flags, pulse done, return to IDLE
module divisor_peso (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  preco,
    input  logic [9:0]  precofr,
    input  logic [9:0]  centimos,
    output logic [11:0] weightInGrams,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_t;

    state_t      state, state_nxt;
    logic [9:0]  preco_q, precofr_q, cent_q;
    logic [9:0]  rem_q;
    logic [26:0] quo_q;      // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [4:0]  cnt_q;
    logic        bad_q;

    logic        bad_in;
    logic [16:0] cents_total;
    logic [10:0] trial;
    logic        ge;

    // Operand validity, total cents and the trial subtraction of the current iteration
    always_comb begin
        bad_in      = (cent_q == 10'd0) || (precofr_q > 10'd99);
        cents_total = 17'(preco_q) * 17'd100 + 17'(precofr_q);
        trial       = {rem_q, quo_q[26]};
        ge          = (trial >= {1'b0, cent_q});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; invalid operands skip the divider entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = bad_in ? FIN : DIV;
            DIV:     if (cnt_q == 5'd0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: operand capture, division iterations and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preco_q       <= '0;
            precofr_q     <= '0;
            cent_q        <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            bad_q         <= 1'b0;
            weightInGrams <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        preco_q   <= preco;
                        precofr_q <= precofr;
                        cent_q    <= centimos;
                    end
                end
                LOAD: begin
                    quo_q <= 27'(cents_total) * 27'd1000;
                    rem_q <= '0;
                    cnt_q <= 5'd26;
                    bad_q <= bad_in;
                end
                DIV: begin
                    // Remainder stays below the 10-bit divisor, so the truncation is exact
                    rem_q <= ge ? 10'(trial - {1'b0, cent_q}) : trial[9:0];
                    quo_q <= {quo_q[25:0], ge};
                    cnt_q <= cnt_q - 5'd1;
                end
                FIN: begin
                    done <= 1'b1;
                    if (bad_q) begin
                        weightInGrams <= '0;
                        err           <= 1'b1;
                        ovf           <= 1'b0;
                    end else if (|quo_q[26:12]) begin
                        weightInGrams <= 12'hFFF;
                        err           <= 1'b0;
                        ovf           <= 1'b1;
                    end else begin
                        weightInGrams <= quo_q[11:0];
                        err           <= 1'b0;
                        ovf           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_peso.sv
// Self-checking bench for divisor_peso: directed cases plus randomized runs
// against an arithmetic reference model.
module tb_divisor_peso;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  preco = '0;
    logic [9:0]  precofr = '0;
    logic [9:0]  centimos = '0;
    logic [11:0] weightInGrams;
    logic        busy, done, err, ovf;

    int total = 0;
    int bad   = 0;

    divisor_peso dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .preco(preco),
        .precofr(precofr),
        .centimos(centimos),
        .weightInGrams(weightInGrams),
        .busy(busy),
        .done(done),
        .err(err),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the stated rules
    function automatic void model(input int p, input int pf, input int c,
                                  output int w, output int e, output int o, output int lat);
        longint q;
        if (c == 0 || pf > 99) begin
            w = 0; e = 1; o = 0; lat = 2;
        end else begin
            q = ((longint'(p) * 100 + longint'(pf)) * 1000) / longint'(c);
            e = 0; lat = 29;
            if (q > 4095) begin w = 4095; o = 1; end
            else          begin w = int'(q); o = 0; end
        end
    endfunction

    task automatic scramble_inputs();
        preco    = 10'($urandom_range(0, 1023));
        precofr  = 10'($urandom_range(0, 1023));
        centimos = 10'($urandom_range(0, 1023));
    endtask

    // One operation: start pulse, inputs scrambled afterwards, optional start re-pulses at cycles 5 and 20
    task automatic run_op(input string tag, input int p, input int pf, input int c, input bit poke);
        int w, e, o, lat, n;
        bit busy_ok;
        model(p, pf, c, w, e, o, lat);
        @(posedge clk); #1;
        preco = 10'(p); precofr = 10'(pf); centimos = 10'(c); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            scramble_inputs();
            start = poke && (n == 5 || n == 20);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, n, lat);
        check({tag, " weight"}, weightInGrams, w);
        check({tag, " err"}, err, e);
        check({tag, " ovf"}, ovf, o);
        check({tag, " busy_during"}, busy_ok, 1);
        check({tag, " busy_at_done"}, busy, 0);
        scramble_inputs();
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, done, 0);
        @(posedge clk); #1;
        check({tag, " weight_hold"}, weightInGrams, w);
        check({tag, " flags_hold"}, {err, ovf}, {e[0], o[0]});
    endtask

    initial begin
        bit saw_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset weight", weightInGrams, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset flags", {err, ovf}, 0);
        rst = 1'b0;

        run_op("p7.05_c470", 7, 5, 470, 1'b0);
        run_op("p1_c300", 1, 0, 300, 1'b0);
        run_op("zero_num", 0, 0, 5, 1'b0);
        run_op("sat", 10, 0, 100, 1'b0);
        run_op("cent_zero", 10, 0, 0, 1'b0);
        run_op("precofr150", 10, 150, 100, 1'b0);
        run_op("precofr99", 0, 99, 1, 1'b0);
        run_op("max_num", 1023, 99, 1023, 1'b0);
        run_op("poke_run", 7, 5, 470, 1'b1);
        run_op("sat_again", 10, 0, 100, 1'b0);

        // Reset in the middle of a run
        @(posedge clk); #1;
        preco = 10'd7; precofr = 10'd5; centimos = 10'd470; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst weight", weightInGrams, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst flags", {err, ovf}, 0);
        saw_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst no_done", saw_done, 0);
        run_op("after_rst", 7, 5, 470, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int p, pf, c;
            p  = $urandom_range(0, 1023);
            pf = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 1023) : $urandom_range(0, 99);
            c  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1023);
            if ($urandom_range(0, 2) == 0) c = $urandom_range(200, 1023);
            run_op($sformatf("rand%0d", i), p, pf, c, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
